// File: rtl/topk_bitonic_merger.sv
// Streaming top-K selector: bitonic-sorts each input batch and merges it
// into a running best-N list with a bitonic half-cleaner network.
module topk_bitonic_merger #(
   parameter int L      = 2,
   parameter int W      = 16,
   parameter int TYPE_W = 3
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       clear,
   input  logic                       ascending,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic                       in_last,
   input  logic [W*(1<<L)-1:0]        in,
   input  logic [TYPE_W*(1<<L)-1:0]   in_type,
   output logic [W*(1<<L)-1:0]        out,
   output logic [TYPE_W*(1<<L)-1:0]   out_type,
   output logic [L:0]                 out_count,
   output logic                       out_valid,
   input  logic                       out_ready
);
   localparam int N  = 1 << L;
   localparam int KW = $clog2(L + 1);

   typedef enum logic [2:0] {IDLE, SORT, SEL, MERGE, DONE} state_t;
   typedef logic [L-1:0] idx_t;
   typedef logic [L:0]   idxw_t;

   state_t state_q, state_d;
   logic asc_q, asc_d;
   logic last_q, last_d;
   logic [KW-1:0] k_q, k_d, j_q, j_d;
   logic [L:0] cnt_q, cnt_d;
   logic [W-1:0] wk_q [N];
   logic [W-1:0] wk_d [N];
   logic [W-1:0] lk_q [N];
   logic [W-1:0] lk_d [N];
   logic [W-1:0] nk [N];
   logic [W-1:0] ck [N];
   logic [TYPE_W-1:0] wt_q [N];
   logic [TYPE_W-1:0] wt_d [N];
   logic [TYPE_W-1:0] lt_q [N];
   logic [TYPE_W-1:0] lt_d [N];
   logic [TYPE_W-1:0] nt [N];
   logic [TYPE_W-1:0] ct [N];
   idx_t  p_idx;
   idxw_t iw;
   logic  up;

   function automatic logic better(input logic a_s, input logic [W-1:0] a,
                                   input logic [W-1:0] b);
      return a_s ? (a < b) : (a > b);
   endfunction

   // One compare-exchange layer: distance 2^j, direction from bit k of index.
   // With k = L every pair runs best-first, which is exactly a half-cleaner.
   always_comb begin
      p_idx = '0;
      iw    = '0;
      up    = 1'b0;
      nk    = wk_q;
      nt    = wt_q;
      for (int i = 0; i < N; i++) begin
         p_idx = idx_t'(i) ^ (idx_t'(1) << j_q);
         iw    = idxw_t'(i);
         up    = ~iw[k_q];
         if (p_idx > idx_t'(i)) begin
            if (up ? better(asc_q, wk_q[p_idx], wk_q[i])
                   : better(asc_q, wk_q[i], wk_q[p_idx])) begin
               nk[i]     = wk_q[p_idx];
               nk[p_idx] = wk_q[i];
               nt[i]     = wt_q[p_idx];
               nt[p_idx] = wt_q[i];
            end
         end
      end
   end

   always_comb begin
      for (int i = 0; i < N; i++) begin
         if (better(asc_q, wk_q[N-1-i], lk_q[i])) begin
            ck[i] = wk_q[N-1-i];
            ct[i] = wt_q[N-1-i];
         end else begin
            ck[i] = lk_q[i];
            ct[i] = lt_q[i];
         end
      end
   end

   always_comb begin
      state_d = state_q;
      asc_d   = asc_q;
      last_d  = last_q;
      k_d     = k_q;
      j_d     = j_q;
      cnt_d   = cnt_q;
      wk_d    = wk_q;
      wt_d    = wt_q;
      lk_d    = lk_q;
      lt_d    = lt_q;
      unique case (state_q)
         IDLE: begin
            if (in_valid) begin
               state_d = SORT;
               last_d  = in_last;
               k_d     = KW'(1);
               j_d     = '0;
               for (int i = 0; i < N; i++) begin
                  wk_d[i] = in[W*i +: W];
                  wt_d[i] = in_type[TYPE_W*i +: TYPE_W];
               end
            end
         end
         SORT: begin
            wk_d = nk;
            wt_d = nt;
            if (j_q == '0) begin
               if (k_q == KW'(L)) begin
                  state_d = SEL;
               end else begin
                  k_d = k_q + 1'b1;
                  j_d = k_q;
               end
            end else begin
               j_d = j_q - 1'b1;
            end
         end
         SEL: begin
            state_d = MERGE;
            wk_d    = ck;
            wt_d    = ct;
            k_d     = KW'(L);
            j_d     = KW'(L - 1);
         end
         MERGE: begin
            wk_d = nk;
            wt_d = nt;
            if (j_q == '0) begin
               lk_d    = nk;
               lt_d    = nt;
               cnt_d   = idxw_t'(N);
               state_d = last_q ? DONE : IDLE;
            end else begin
               j_d = j_q - 1'b1;
            end
         end
         DONE: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      if (clear) begin
         state_d = IDLE;
         asc_d   = ascending;
         cnt_d   = '0;
         for (int i = 0; i < N; i++) begin
            lk_d[i] = {W{ascending}};
            lt_d[i] = '0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         asc_q   <= ascending;
         last_q  <= 1'b0;
         k_q     <= '0;
         j_q     <= '0;
         cnt_q   <= '0;
         for (int i = 0; i < N; i++) begin
            lk_q[i] <= {W{ascending}};
            lt_q[i] <= '0;
            wk_q[i] <= '0;
            wt_q[i] <= '0;
         end
      end else begin
         state_q <= state_d;
         asc_q   <= asc_d;
         last_q  <= last_d;
         k_q     <= k_d;
         j_q     <= j_d;
         cnt_q   <= cnt_d;
         lk_q    <= lk_d;
         lt_q    <= lt_d;
         wk_q    <= wk_d;
         wt_q    <= wt_d;
      end
   end

   always_comb begin
      for (int i = 0; i < N; i++) begin
         out[W*i +: W]                = lk_q[i];
         out_type[TYPE_W*i +: TYPE_W] = lt_q[i];
      end
   end

   assign out_count = cnt_q;
   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);

endmodule

// File: tb/tb_topk_bitonic_merger.sv
// Randomised and directed bench for topk_bitonic_merger against a
// sort-the-union reference model of the best-N list.
module tb_topk_bitonic_merger;
   localparam int L  = 2;
   localparam int W  = 8;
   localparam int TW = 3;
   localparam int N  = 4;

   logic clk = 1'b0;
   logic rst, clear, ascending, in_valid, in_ready, in_last;
   logic out_valid, out_ready;
   logic [W*N-1:0]  in_k, out_k;
   logic [TW*N-1:0] in_t, out_t;
   logic [L:0]      out_count;

   always #5 clk = ~clk;

   topk_bitonic_merger #(.L(L), .W(W), .TYPE_W(TW)) dut (
      .clk(clk), .rst(rst), .clear(clear), .ascending(ascending),
      .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
      .in(in_k), .in_type(in_t), .out(out_k), .out_type(out_t),
      .out_count(out_count), .out_valid(out_valid), .out_ready(out_ready)
   );

   int n_checks = 0;
   int n_fail   = 0;

   logic [W-1:0]  m_key [N];
   logic [TW-1:0] m_typ [N];
   int            m_cnt;
   bit            m_asc;

   function automatic bit better(input bit asc, input logic [W-1:0] a,
                                 input logic [W-1:0] b);
      return asc ? (a < b) : (a > b);
   endfunction

   function automatic logic [W*N-1:0] pk(input logic [W-1:0] a [N]);
      logic [W*N-1:0] r;
      r = '0;
      for (int i = 0; i < N; i++) r[W*i +: W] = a[i];
      return r;
   endfunction

   function automatic logic [TW*N-1:0] pt(input logic [TW-1:0] a [N]);
      logic [TW*N-1:0] r;
      r = '0;
      for (int i = 0; i < N; i++) r[TW*i +: TW] = a[i];
      return r;
   endfunction

   task automatic model_clear(input bit asc);
      m_asc = asc;
      m_cnt = 0;
      for (int i = 0; i < N; i++) begin
         m_key[i] = asc ? 8'hFF : 8'h00;
         m_typ[i] = '0;
      end
   endtask

   // Best N of (list U batch), best-first.
   task automatic model_merge(input logic [W-1:0] bk [N],
                              input logic [TW-1:0] bt [N]);
      logic [W-1:0]  ak [2*N];
      logic [TW-1:0] at [2*N];
      logic [W-1:0]  tk;
      logic [TW-1:0] tt;
      for (int i = 0; i < N; i++) begin
         ak[i] = m_key[i];   at[i] = m_typ[i];
         ak[N+i] = bk[i];    at[N+i] = bt[i];
      end
      for (int i = 0; i < 2*N; i++)
         for (int j = i + 1; j < 2*N; j++)
            if (better(m_asc, ak[j], ak[i])) begin
               tk = ak[i]; ak[i] = ak[j]; ak[j] = tk;
               tt = at[i]; at[i] = at[j]; at[j] = tt;
            end
      for (int i = 0; i < N; i++) begin
         m_key[i] = ak[i];
         m_typ[i] = at[i];
      end
      m_cnt = (m_cnt + N > N) ? N : m_cnt + N;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_clear(input bit asc);
      clear = 1'b1;
      ascending = asc;
      step();
      clear = 1'b0;
      ascending = ~asc;
      model_clear(asc);
   endtask

   task automatic handshake();
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
   endtask

   task automatic send(input logic [W-1:0] bk [N],
                       input logic [TW-1:0] bt [N], input bit last);
      int w;
      w = 0;
      while (!in_ready && w < 100) begin
         step();
         w++;
      end
      n_checks++;
      if (in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL send_ready: in_ready=%b required 1", in_ready);
      end
      in_valid = 1'b1;
      in_k = pk(bk);
      in_t = pt(bt);
      in_last = last;
      step();
      in_valid = 1'b0;
      in_k = $urandom;
      in_t = $urandom;
      in_last = $urandom;
   endtask

   task automatic wait_busy(output int cyc);
      cyc = 0;
      while (!in_ready && !out_valid && cyc < 100) begin
         step();
         cyc++;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      ascending = 1'b1;
      step();
      step();
      rst = 1'b0;
      ascending = 1'b0;
      n_checks += 5;
      if (out_k !== 32'hFFFFFFFF) begin
         n_fail++; $display("FAIL reset_out: got %h required ffffffff", out_k);
      end
      if (out_t !== '0) begin
         n_fail++; $display("FAIL reset_type: got %h required 0", out_t);
      end
      if (out_count !== 3'd0) begin
         n_fail++; $display("FAIL reset_count: got %0d required 0", out_count);
      end
      if (in_ready !== 1'b1) begin
         n_fail++; $display("FAIL reset_in_ready: got %b required 1", in_ready);
      end
      if (out_valid !== 1'b0) begin
         n_fail++; $display("FAIL reset_out_valid: got %b required 0", out_valid);
      end
      model_clear(1'b1);
   endtask

   task automatic test_single();
      logic [W-1:0]  bk [N];
      logic [TW-1:0] bt [N];
      logic [W-1:0]  ek [N];
      logic [TW-1:0] et [N];
      int cyc;
      do_clear(1'b1);
      bk = '{8'd9, 8'd3, 8'd7, 8'd1};
      bt = '{3'd0, 3'd1, 3'd2, 3'd3};
      ek = '{8'd1, 8'd3, 8'd7, 8'd9};
      et = '{3'd3, 3'd1, 3'd2, 3'd0};
      send(bk, bt, 1'b1);
      wait_busy(cyc);
      n_checks += 5;
      if (cyc != 6) begin
         n_fail++; $display("FAIL single_busy: got %0d cycles required 6", cyc);
      end
      if (out_valid !== 1'b1) begin
         n_fail++; $display("FAIL single_valid: got %b required 1", out_valid);
      end
      if (out_k !== pk(ek)) begin
         n_fail++; $display("FAIL single_out: got %h required %h", out_k, pk(ek));
      end
      if (out_t !== pt(et)) begin
         n_fail++; $display("FAIL single_type: got %h required %h", out_t, pt(et));
      end
      if (out_count !== 3'd4) begin
         n_fail++; $display("FAIL single_count: got %0d required 4", out_count);
      end
      handshake();
      n_checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL single_release: in_ready=%b out_valid=%b required 1/0",
                  in_ready, out_valid);
      end
   endtask

   task automatic test_two_batches(input bit asc);
      logic [W-1:0]  bk [N];
      logic [TW-1:0] bt [N];
      logic [W-1:0]  ek [N];
      int cyc;
      do_clear(asc);
      bk = '{8'd9, 8'd3, 8'd7, 8'd1};
      bt = '{3'd0, 3'd1, 3'd2, 3'd3};
      send(bk, bt, 1'b0);
      model_merge(bk, bt);
      wait_busy(cyc);
      n_checks += 3;
      if (cyc != 6 || in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL two_first_busy: got %0d cycles in_ready=%b required 6/1",
                  cyc, in_ready);
      end
      if (out_k !== pk(m_key)) begin
         n_fail++; $display("FAIL two_first_out: got %h required %h", out_k, pk(m_key));
      end
      if (out_valid !== 1'b0) begin
         n_fail++; $display("FAIL two_first_valid: got %b required 0", out_valid);
      end
      bk = '{8'd2, 8'd8, 8'd0, 8'd5};
      bt = '{3'd4, 3'd5, 3'd6, 3'd7};
      send(bk, bt, 1'b1);
      model_merge(bk, bt);
      wait_busy(cyc);
      if (asc) ek = '{8'd0, 8'd1, 8'd2, 8'd3};
      else     ek = '{8'd9, 8'd8, 8'd7, 8'd5};
      n_checks += 4;
      if (out_valid !== 1'b1) begin
         n_fail++; $display("FAIL two_valid asc=%0d: got %b required 1", asc, out_valid);
      end
      if (out_k !== pk(ek)) begin
         n_fail++; $display("FAIL two_out asc=%0d: got %h required %h", asc, out_k, pk(ek));
      end
      if (out_t !== pt(m_typ)) begin
         n_fail++; $display("FAIL two_type asc=%0d: got %h required %h", asc, out_t, pt(m_typ));
      end
      if (out_count !== 3'd4) begin
         n_fail++; $display("FAIL two_count asc=%0d: got %0d required 4", asc, out_count);
      end
      handshake();
   endtask

   task automatic test_hold();
      logic [W-1:0]  bk [N];
      logic [TW-1:0] bt [N];
      int cyc;
      do_clear(1'b0);
      bk = '{8'd40, 8'd12, 8'd99, 8'd7};
      bt = '{3'd1, 3'd6, 3'd2, 3'd5};
      send(bk, bt, 1'b1);
      model_merge(bk, bt);
      wait_busy(cyc);
      for (int c = 0; c < 10; c++) begin
         step();
         n_checks++;
         if (out_k !== pk(m_key) || out_t !== pt(m_typ) || in_ready !== 1'b0
             || out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL hold_c%0d: out=%h type=%h rdy=%b vld=%b required %h %h 0 1",
                     c, out_k, out_t, in_ready, out_valid, pk(m_key), pt(m_typ));
         end
      end
      handshake();
      n_checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_k !== pk(m_key)) begin
         n_fail++;
         $display("FAIL hold_release: rdy=%b vld=%b out=%h required 1 0 %h",
                  in_ready, out_valid, out_k, pk(m_key));
      end
   endtask

   task automatic test_clear_abort();
      logic [W-1:0]  bk [N];
      logic [TW-1:0] bt [N];
      int cyc;
      do_clear(1'b1);
      bk = '{8'd5, 8'd6, 8'd2, 8'd1};
      bt = '{3'd7, 3'd7, 3'd7, 3'd7};
      send(bk, bt, 1'b1);
      step();
      clear = 1'b1;
      ascending = 1'b1;
      step();
      clear = 1'b0;
      ascending = 1'b0;
      model_clear(1'b1);
      n_checks++;
      if (in_ready !== 1'b1 || out_k !== 32'hFFFFFFFF || out_count !== 3'd0
          || out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL clear_abort: rdy=%b out=%h cnt=%0d vld=%b required 1 ffffffff 0 0",
                  in_ready, out_k, out_count, out_valid);
      end
      for (int c = 0; c < 8; c++) step();
      n_checks++;
      if (out_k !== 32'hFFFFFFFF || in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL clear_settle: out=%h rdy=%b required ffffffff 1", out_k, in_ready);
      end
      bk = '{8'd50, 8'd30, 8'd40, 8'd20};
      bt = '{3'd1, 3'd2, 3'd3, 3'd4};
      send(bk, bt, 1'b1);
      model_merge(bk, bt);
      wait_busy(cyc);
      n_checks++;
      if (out_valid !== 1'b1 || out_k !== pk(m_key) || out_t !== pt(m_typ)) begin
         n_fail++;
         $display("FAIL clear_next: vld=%b out=%h type=%h required 1 %h %h",
                  out_valid, out_k, out_t, pk(m_key), pt(m_typ));
      end
      handshake();
   endtask

   task automatic test_equal();
      logic [W-1:0]  bk [N];
      logic [TW-1:0] bt [N];
      logic [TW-1:0] lab;
      int cyc;
      do_clear(1'b1);
      bk = '{8'd4, 8'd4, 8'd4, 8'd4};
      bt = '{3'd1, 3'd2, 3'd3, 3'd4};
      send(bk, bt, 1'b0);
      wait_busy(cyc);
      bt = '{3'd5, 3'd6, 3'd7, 3'd0};
      send(bk, bt, 1'b1);
      wait_busy(cyc);
      n_checks += 2;
      if (out_k !== 32'h04040404) begin
         n_fail++; $display("FAIL equal_keys: got %h required 04040404", out_k);
      end
      if (out_count !== 3'd4) begin
         n_fail++; $display("FAIL equal_count: got %0d required 4", out_count);
      end
      for (int i = 0; i < N; i++) begin
         lab = out_t[TW*i +: TW];
         n_checks++;
         if (lab < 3'd1 || lab > 3'd4) begin
            n_fail++;
            $display("FAIL equal_label%0d: got %0d required one of 1..4", i, lab);
         end
      end
      handshake();
   endtask

   task automatic test_rst_mid();
      logic [W-1:0]  bk [N];
      logic [TW-1:0] bt [N];
      int cyc;
      do_clear(1'b1);
      bk = '{8'd200, 8'd201, 8'd202, 8'd203};
      bt = '{3'd1, 3'd1, 3'd1, 3'd1};
      send(bk, bt, 1'b1);
      step();
      rst = 1'b1;
      clear = 1'b1;
      ascending = 1'b0;
      step();
      rst = 1'b0;
      clear = 1'b0;
      ascending = 1'b1;
      model_clear(1'b0);
      n_checks++;
      if (out_k !== 32'h0 || out_count !== 3'd0 || in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL rst_mid: out=%h cnt=%0d rdy=%b required 0 0 1",
                  out_k, out_count, in_ready);
      end
      bk = '{8'd11, 8'd77, 8'd33, 8'd55};
      bt = '{3'd2, 3'd3, 3'd4, 3'd5};
      send(bk, bt, 1'b1);
      model_merge(bk, bt);
      wait_busy(cyc);
      n_checks++;
      if (out_valid !== 1'b1 || out_k !== pk(m_key) || out_t !== pt(m_typ)) begin
         n_fail++;
         $display("FAIL rst_next: vld=%b out=%h type=%h required 1 %h %h",
                  out_valid, out_k, out_t, pk(m_key), pt(m_typ));
      end
      handshake();
   endtask

   task automatic test_random();
      logic [W-1:0]  bk [N];
      logic [TW-1:0] bt [N];
      bit used [256];
      int nb, cyc, v;
      bit asc, last;
      for (int q = 0; q < 8; q++) begin
         asc = 1'($urandom_range(1, 0));
         do_clear(asc);
         for (int u = 0; u < 256; u++) used[u] = 1'b0;
         nb = $urandom_range(4, 1);
         for (int b = 0; b < nb; b++) begin
            for (int i = 0; i < N; i++) begin
               do v = $urandom_range(254, 1); while (used[v]);
               used[v] = 1'b1;
               bk[i] = W'(v);
               bt[i] = TW'($urandom_range(7, 0));
            end
            last = (b == nb - 1);
            send(bk, bt, last);
            model_merge(bk, bt);
            wait_busy(cyc);
            n_checks++;
            if (cyc != 6 || out_valid !== last || out_k !== pk(m_key)
                || out_t !== pt(m_typ) || out_count !== 3'(m_cnt)) begin
               n_fail++;
               $display("FAIL rand_q%0d_b%0d: cyc=%0d vld=%b out=%h type=%h cnt=%0d required 6 %b %h %h %0d",
                        q, b, cyc, out_valid, out_k, out_t, out_count,
                        last, pk(m_key), pt(m_typ), m_cnt);
            end
         end
         handshake();
      end
   endtask

   initial begin
      rst = 1'b1; clear = 1'b0; ascending = 1'b1;
      in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
      in_k = '0; in_t = '0;
      test_reset();
      test_single();
      test_two_batches(1'b1);
      test_two_batches(1'b0);
      test_hold();
      test_clear_abort();
      test_equal();
      test_rst_mid();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/topk_bitonic_merger.md
TOPK_BITONIC_MERGER -- requirements
Module: topk_bitonic_merger

Interface
REQ-001 SHALL have parameter L, default 2, meaning log2 of batch size and list size (N = 1<<L, L >= 1).
REQ-002 SHALL have parameter W, default 16, meaning distance key width.
REQ-003 SHALL have parameter TYPE_W, default 3, meaning label width carried with each key.
REQ-004 SHALL have port clk  input  1  meaning the single clock; all logic on its rising edge.
REQ-005 SHALL have port rst  input  1  meaning the reset, synchronous and active-high.
REQ-006 SHALL have port clear  input  1  meaning start a new query: reinitialise the list and latch ascending.
REQ-007 SHALL have port ascending  input  1  meaning 1 = keep the N smallest keys, 0 = keep the N largest; sampled only on clear or rst.
REQ-008 SHALL have port in_valid  input  1  meaning the batch on in/in_type is valid.
REQ-009 SHALL have port in_ready  output  1  meaning the block can accept a batch this cycle.
REQ-010 SHALL have port in_last  input  1  meaning the accepted batch is the final batch of the query.
REQ-011 SHALL have port in  input  W*N  meaning N unsorted keys; element i in bits [W*(i+1)-1:W*i].
REQ-012 SHALL have port in_type  input  TYPE_W*N  meaning the labels, packed the same way as in.
REQ-013 SHALL have port out  output  W*N  meaning the current best list, sorted best-first at element 0.
REQ-014 SHALL have port out_type  output  TYPE_W*N  meaning the labels paired with out.
REQ-015 SHALL have port out_count  output  L+1  meaning the number of real entries in the list, saturating at N.
REQ-016 SHALL have port out_valid  output  1  meaning the final result is presented.
REQ-017 SHALL have port out_ready  input  1  meaning the consumer accepts the result.

Function
REQ-018 SHALL implement states IDLE, SORT, SEL, MERGE and DONE; in_ready = 1 only in IDLE; out_valid = 1 only in DONE.
REQ-019 SHALL accept a batch on a cycle with in_valid & in_ready, move to SORT, and register the batch and in_last.
REQ-020 SHALL in SORT apply one bitonic-sort network stage per cycle to the registered batch for L(L+1)/2 cycles, yielding the batch sorted best-first.
REQ-021 SHALL in SEL, for one cycle, form cand[i] = better of list[i] and batch[N-1-i]; ties keep list[i].
REQ-022 SHALL in MERGE apply L bitonic half-cleaner stages, one per cycle, to cand; the result SHALL be written to the list, sorted best-first.
REQ-023 SHALL define "better" as strictly less when ascending = 1 and strictly greater when ascending = 0; compare-exchange SHALL swap only on strict inequality, and each label SHALL travel with its key.
REQ-024 SHALL, after MERGE, go to DONE if the registered in_last = 1, else to IDLE; busy time per batch is exactly L(L+1)/2 + 1 + L cycles (6 for L = 2).
REQ-025 SHALL in DONE hold out/out_type/out_count stable, and return to IDLE with the list unchanged on out_valid & out_ready.
REQ-026 SHALL update out_count to min(out_count + N, N) at the end of MERGE.
REQ-027 SHALL have out continuously reflect the list register, which updates only at the end of MERGE, clear or reset.
REQ-028 SHALL, on clear in any state, fill the list with the sentinel (all ones if the new ascending = 1, all zeros if 0), set labels to 0 and out_count to 0, abort any batch in flight, and enter IDLE the next cycle; clear SHALL take priority over acceptance and DONE handshakes.
REQ-029 SHALL ignore in_valid when in_ready = 0; no input data SHALL be required to be held after acceptance.

Reset
REQ-030 SHALL, on rst, enter IDLE, latch ascending, fill the list with the sentinel, and set labels 0, out_count 0, in_ready 1 and out_valid 0; rst SHALL take priority over clear.
REQ-031 SHALL, on rst mid-operation, discard the batch in flight, and the next batch after reset SHALL be processed from the sentinel list.

Verification (L=2, W=8, TYPE_W=3)
REQ-032 SHALL cover: rst with ascending = 1 -> out = {FF,FF,FF,FF}, out_count = 0, in_ready = 1, out_valid = 0.
REQ-033 SHALL cover: ascending = 1, batch {9,3,7,1} with types {0,1,2,3} and in_last = 1 -> in_ready low for 6 cycles, then out_valid with out = {1,3,7,9}, types {3,1,2,0}, out_count = 4.
REQ-034 SHALL cover: batches {9,3,7,1}, then {2,8,0,5} with last -> out = {0,1,2,3}; with ascending = 0 (same data) -> out = {9,8,7,5}.
REQ-035 SHALL cover: out_ready held low for 10 cycles in DONE -> out stable and in_ready = 0; out_ready = 1 -> IDLE next cycle.
REQ-036 SHALL cover: clear asserted 2 cycles into SORT -> IDLE next cycle, list = sentinel, and the aborted batch does not appear.
REQ-037 SHALL cover: equal keys {4,4,4,4} merged into list {4,4,4,4} -> keys all 4, out_count = 4, and every output label drawn from the original list.
